// File: rtl/scariv_lsu_pkg.sv
// rtl/scariv_lsu_pkg.sv - shared LSU types, constants and age-compare helper
//
// Purpose: common definitions for the LSU replay arbiter slice.
//   LSU_*_W            : default field widths of an LSU request
//   LSU_ARB_STARVE_MAX : replay grants in a row (issue pending) before issue is forced
//   lsu_arb_req_t      : request carried through the EX0 register
//   is_younger()       : 1 when (cmt_a, grp_a) is younger than (cmt_b, grp_b)
package scariv_lsu_pkg;

    localparam int LSU_CMT_ID_W       = 6;
    localparam int LSU_GRP_W          = 4;
    localparam int LSU_PAYLOAD_W      = 128;
    localparam int LSU_ARB_STARVE_MAX = 7;

    typedef struct packed {
        logic [LSU_CMT_ID_W-1:0]  cmt_id;
        logic [LSU_GRP_W-1:0]     grp_id;
        logic [LSU_PAYLOAD_W-1:0] payload;
    } lsu_arb_req_t;

    // cmt_id MSB is a wrap bit: with equal wrap bits a larger index is younger,
    // with differing wrap bits the index order is inverted. Within one cmt_id
    // the one-hot grp_id orders the dispatch lanes.
    function automatic logic is_younger(
        input logic [LSU_CMT_ID_W-1:0] cmt_a,
        input logic [LSU_GRP_W-1:0]    grp_a,
        input logic [LSU_CMT_ID_W-1:0] cmt_b,
        input logic [LSU_GRP_W-1:0]    grp_b
    );
        logic                    wrap_eq;
        logic [LSU_CMT_ID_W-2:0] idx_a;
        logic [LSU_CMT_ID_W-2:0] idx_b;
        wrap_eq = (cmt_a[LSU_CMT_ID_W-1] == cmt_b[LSU_CMT_ID_W-1]);
        idx_a   = cmt_a[LSU_CMT_ID_W-2:0];
        idx_b   = cmt_b[LSU_CMT_ID_W-2:0];
        return (wrap_eq && (idx_a > idx_b)) ||
               (!wrap_eq && (idx_a < idx_b)) ||
               ((cmt_a == cmt_b) && (grp_a > grp_b));
    endfunction

endpackage

// File: rtl/scariv_lsu_replay_arbiter_if.sv
// rtl/scariv_lsu_replay_arbiter_if.sv - request/flush/EX0 bundle of the replay arbiter
//
// Purpose: groups every non-clock/reset signal of the arbiter.
//   iss_*   : issue scheduler request channel (valid/ready + cmt_id, grp_id, payload)
//   rpl_*   : replay queue request channel plus rpl_almost_full
//   commit_flush, br_* : flush controls
//   ex0_*   : EX0 register output channel (valid/ready + data + is_replay)
// Modports: slave = arbiter side, master = surrounding pipeline / bench side.
interface scariv_lsu_replay_arbiter_if #(
    parameter int CMT_ID_W  = scariv_lsu_pkg::LSU_CMT_ID_W,
    parameter int GRP_W     = scariv_lsu_pkg::LSU_GRP_W,
    parameter int PAYLOAD_W = scariv_lsu_pkg::LSU_PAYLOAD_W
) ();

    logic                 iss_valid;
    logic                 iss_ready;
    logic [CMT_ID_W-1:0]  iss_cmt_id;
    logic [GRP_W-1:0]     iss_grp_id;
    logic [PAYLOAD_W-1:0] iss_payload;

    logic                 rpl_valid;
    logic                 rpl_ready;
    logic [CMT_ID_W-1:0]  rpl_cmt_id;
    logic [GRP_W-1:0]     rpl_grp_id;
    logic [PAYLOAD_W-1:0] rpl_payload;
    logic                 rpl_almost_full;

    logic                 commit_flush;
    logic                 br_flush;
    logic [CMT_ID_W-1:0]  br_cmt_id;
    logic [GRP_W-1:0]     br_grp_id;

    logic                 ex0_valid;
    logic                 ex0_ready;
    logic [CMT_ID_W-1:0]  ex0_cmt_id;
    logic [GRP_W-1:0]     ex0_grp_id;
    logic [PAYLOAD_W-1:0] ex0_payload;
    logic                 ex0_is_replay;

    modport slave (
        input  iss_valid, iss_cmt_id, iss_grp_id, iss_payload,
        output iss_ready,
        input  rpl_valid, rpl_cmt_id, rpl_grp_id, rpl_payload, rpl_almost_full,
        output rpl_ready,
        input  commit_flush, br_flush, br_cmt_id, br_grp_id,
        output ex0_valid, ex0_cmt_id, ex0_grp_id, ex0_payload, ex0_is_replay,
        input  ex0_ready
    );

    modport master (
        output iss_valid, iss_cmt_id, iss_grp_id, iss_payload,
        input  iss_ready,
        output rpl_valid, rpl_cmt_id, rpl_grp_id, rpl_payload, rpl_almost_full,
        input  rpl_ready,
        output commit_flush, br_flush, br_cmt_id, br_grp_id,
        input  ex0_valid, ex0_cmt_id, ex0_grp_id, ex0_payload, ex0_is_replay,
        output ex0_ready
    );

endinterface

// File: rtl/scariv_lsu_arb_stage_reg.sv
// rtl/scariv_lsu_arb_stage_reg.sv - single-entry valid/ready register with kill
//
// Purpose: holds one request for EX0.
//   i_clk, i_reset_n  : clock, async active-low reset (clears valid and is_replay)
//   i_load_valid      : load i_load_data / i_load_is_replay at the next edge
//   i_ready           : downstream consumes the held entry this cycle
//   i_kill            : held entry is flushed
//   o_valid, o_data, o_is_replay : held entry
// The caller only asserts i_load_valid when the slot is free (empty or
// draining), so a stalled entry is never overwritten here.
module scariv_lsu_arb_stage_reg
    import scariv_lsu_pkg::*;
#(
    parameter type T = lsu_arb_req_t
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load_valid,
    input  T     i_load_data,
    input  logic i_load_is_replay,
    input  logic i_ready,
    input  logic i_kill,
    output logic o_valid,
    output T     o_data,
    output logic o_is_replay
);

    logic valid_q;
    logic valid_d;
    logic is_replay_q;
    logic is_replay_d;
    T     data_q;

    // Load has priority: a drain and a load in the same edge replace the entry.
    always_comb begin
        valid_d     = valid_q;
        is_replay_d = is_replay_q;
        if (i_load_valid) begin
            valid_d     = 1'b1;
            is_replay_d = i_load_is_replay;
        end else if (valid_q && (i_ready || i_kill)) begin
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= 1'b0;
            is_replay_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            is_replay_q <= is_replay_d;
        end
    end

    // Data contents are don't-care while invalid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (i_load_valid) begin
            data_q <= i_load_data;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_is_replay = is_replay_q;

endmodule

// File: rtl/scariv_lsu_replay_arbiter.sv
// rtl/scariv_lsu_replay_arbiter.sv - issue vs fast-replay arbiter feeding LSU EX0
//
// Purpose: each cycle picks between the issue scheduler request and the
// replay queue request, registers the winner into the EX0 stage and applies
// commit / branch flushes to both the incoming winner and the held entry.
//   i_clk, i_reset_n : clock, async active-low reset
//   bus (slave)      : issue, replay, flush and EX0 channels
// Replay wins by default; after STARVE_MAX consecutive replay grants with
// issue pending, issue gets one forced grant. Issue is fully blocked while
// the replay queue reports almost full.
module scariv_lsu_replay_arbiter
    import scariv_lsu_pkg::*;
#(
    parameter int CMT_ID_W   = LSU_CMT_ID_W,
    parameter int GRP_W      = LSU_GRP_W,
    parameter int PAYLOAD_W  = LSU_PAYLOAD_W,
    parameter int STARVE_MAX = LSU_ARB_STARVE_MAX
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    scariv_lsu_replay_arbiter_if.slave  bus
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic                 slot_free;
    logic                 force_iss;
    logic                 grant_rpl;
    logic                 grant_iss;

    logic [CMT_ID_W-1:0]  win_cmt_id;
    logic [GRP_W-1:0]     win_grp_id;
    logic [PAYLOAD_W-1:0] win_payload;
    logic                 win_kill;
    logic                 load_valid;
    lsu_arb_req_t         win_req;

    logic                 held_valid;
    logic                 held_is_replay;
    logic                 held_kill;
    lsu_arb_req_t         held_req;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign slot_free = ~held_valid | bus.ex0_ready;
    assign force_iss = (cnt_q == CNT_MAX) & bus.iss_valid & ~bus.rpl_almost_full;
    assign grant_rpl = slot_free & bus.rpl_valid & ~force_iss;
    assign grant_iss = slot_free & bus.iss_valid & ~bus.rpl_almost_full & ~grant_rpl;

    assign bus.rpl_ready = grant_rpl;
    assign bus.iss_ready = grant_iss;

    // Counts replay grants that left a pending issue request waiting.
    // Saturation (rather than wrap) keeps issue eligible for the forced
    // grant as soon as almost-full drops.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_iss || !bus.iss_valid) begin
            cnt_d = '0;
        end else if (grant_rpl) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Winner select and flush
    // ------------------------------------------------------------------
    assign win_cmt_id  = grant_rpl ? bus.rpl_cmt_id  : bus.iss_cmt_id;
    assign win_grp_id  = grant_rpl ? bus.rpl_grp_id  : bus.iss_grp_id;
    assign win_payload = grant_rpl ? bus.rpl_payload : bus.iss_payload;

    assign win_req.cmt_id  = win_cmt_id;
    assign win_req.grp_id  = win_grp_id;
    assign win_req.payload = win_payload;

    // A killed winner is still acknowledged upstream (ready stays high) so
    // the source drops it; it just never reaches EX0.
    assign win_kill   = bus.commit_flush |
                        (bus.br_flush & is_younger(win_cmt_id, win_grp_id,
                                                   bus.br_cmt_id, bus.br_grp_id));
    assign load_valid = (grant_rpl | grant_iss) & ~win_kill;

    assign held_kill  = bus.commit_flush |
                        (bus.br_flush & is_younger(held_req.cmt_id, held_req.grp_id,
                                                   bus.br_cmt_id, bus.br_grp_id));

    // ------------------------------------------------------------------
    // EX0 register
    // ------------------------------------------------------------------
    scariv_lsu_arb_stage_reg #(
        .T (lsu_arb_req_t)
    ) u_stage_reg (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_load_valid     (load_valid),
        .i_load_data      (win_req),
        .i_load_is_replay (grant_rpl),
        .i_ready          (bus.ex0_ready),
        .i_kill           (held_kill),
        .o_valid          (held_valid),
        .o_data           (held_req),
        .o_is_replay      (held_is_replay)
    );

    assign bus.ex0_valid     = held_valid;
    assign bus.ex0_cmt_id    = held_req.cmt_id;
    assign bus.ex0_grp_id    = held_req.grp_id;
    assign bus.ex0_payload   = held_req.payload;
    assign bus.ex0_is_replay = held_is_replay;

endmodule

// File: tb/tb_scariv_lsu_replay_arbiter.sv
// tb/tb_scariv_lsu_replay_arbiter.sv - scoreboard bench for the LSU replay arbiter
module tb_scariv_lsu_replay_arbiter;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clk = ~i_clk;

    scariv_lsu_replay_arbiter_if bus ();

    scariv_lsu_replay_arbiter #(
        .CMT_ID_W   (6),
        .GRP_W      (4),
        .PAYLOAD_W  (128),
        .STARVE_MAX (7)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    typedef struct {
        logic iss;
        logic rpl;
        logic v;
        logic chk_rep;
    } cyc_t;

    typedef struct {
        logic [5:0]   cmt;
        logic [3:0]   grp;
        logic [127:0] pl;
        logic         rep;
    } xfer_t;

    cyc_t  cyc_q[$];
    xfer_t xfer_q[$];

    int    checks   = 0;
    int    failures = 0;
    logic  end_chk  = 1'b0;
    logic  end_done = 1'b0;
    cyc_t  mon_e;
    xfer_t mon_x;

    function automatic logic [127:0] pl_of(input logic [5:0] c, input logic r);
        logic [15:0] w;
        w = (r ? 16'h5A00 : 16'hA500) | {10'd0, c};
        return {8{w}};
    endfunction

    // Monitor: per-cycle handshake/valid expectations and EX0 transfers.
    always @(negedge i_clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            checks++;
            if ({bus.iss_ready, bus.rpl_ready, bus.ex0_valid} !== {mon_e.iss, mon_e.rpl, mon_e.v}) begin
                failures++;
                $display("FAIL cycle_ctrl at %0t: iss_ready/rpl_ready/ex0_valid got %b%b%b want %b%b%b",
                         $time, bus.iss_ready, bus.rpl_ready, bus.ex0_valid, mon_e.iss, mon_e.rpl, mon_e.v);
            end
            if (mon_e.chk_rep) begin
                checks++;
                if (bus.ex0_is_replay !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_is_replay at %0t: got %b want 0", $time, bus.ex0_is_replay);
                end
            end
        end
        if (i_reset_n && bus.ex0_valid && bus.ex0_ready) begin
            checks++;
            if (xfer_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_xfer at %0t: got cmt_id %h with nothing expected", $time, bus.ex0_cmt_id);
            end else begin
                mon_x = xfer_q.pop_front();
                if ({bus.ex0_cmt_id, bus.ex0_grp_id, bus.ex0_payload, bus.ex0_is_replay} !==
                    {mon_x.cmt, mon_x.grp, mon_x.pl, mon_x.rep}) begin
                    failures++;
                    $display("FAIL ex0_xfer at %0t: got cmt=%h grp=%b rep=%b pl=%h want cmt=%h grp=%b rep=%b pl=%h",
                             $time, bus.ex0_cmt_id, bus.ex0_grp_id, bus.ex0_is_replay, bus.ex0_payload,
                             mon_x.cmt, mon_x.grp, mon_x.rep, mon_x.pl);
                end
            end
        end
        if (end_chk && !end_done) begin
            end_done = 1'b1;
            checks++;
            if (xfer_q.size() != 0 || cyc_q.size() != 0) begin
                failures++;
                $display("FAIL drain_empty: got %0d xfers and %0d cycles left want 0 and 0",
                         xfer_q.size(), cyc_q.size());
            end
        end
    end

    task automatic drive_idle();
        bus.iss_valid       = 1'b0;
        bus.iss_cmt_id      = '0;
        bus.iss_grp_id      = '0;
        bus.iss_payload     = '0;
        bus.rpl_valid       = 1'b0;
        bus.rpl_cmt_id      = '0;
        bus.rpl_grp_id      = '0;
        bus.rpl_payload     = '0;
        bus.rpl_almost_full = 1'b0;
        bus.commit_flush    = 1'b0;
        bus.br_flush        = 1'b0;
        bus.br_cmt_id       = '0;
        bus.br_grp_id       = '0;
        bus.ex0_ready       = 1'b0;
    endtask

    // One cycle of stimulus with the hand-computed handshake expectation.
    task automatic step(input logic iv, input logic [5:0] ic,
                        input logic rv, input logic [5:0] rc,
                        input logic af, input logic rdy,
                        input logic cf, input logic bf, input logic [5:0] bc,
                        input logic e_iss, input logic e_rpl, input logic e_v);
        bus.iss_valid       = iv;
        bus.iss_cmt_id      = ic;
        bus.iss_grp_id      = 4'b0001;
        bus.iss_payload     = pl_of(ic, 1'b0);
        bus.rpl_valid       = rv;
        bus.rpl_cmt_id      = rc;
        bus.rpl_grp_id      = 4'b0010;
        bus.rpl_payload     = pl_of(rc, 1'b1);
        bus.rpl_almost_full = af;
        bus.ex0_ready       = rdy;
        bus.commit_flush    = cf;
        bus.br_flush        = bf;
        bus.br_cmt_id       = bc;
        bus.br_grp_id       = 4'b0001;
        cyc_q.push_back('{e_iss, e_rpl, e_v, 1'b0});
        if (e_rpl && !cf)
            xfer_q.push_back('{rc, 4'b0010, pl_of(rc, 1'b1), 1'b1});
        else if (e_iss && !cf)
            xfer_q.push_back('{ic, 4'b0001, pl_of(ic, 1'b0), 1'b0});
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        drive_idle();
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        // Reset state
        cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // 1: lone issue request
        step(1, 6'h05, 0, 6'h00, 0, 1, 0, 0, 6'h00, 1, 0, 0);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 1);

        // 2: both valid -> 7 replay grants then one forced issue grant, twice
        for (int k = 0; k < 16; k++) begin
            step(1, 6'h08, 1, 6'(6'h10 + k), 0, 1, 0, 0, 6'h00,
                 (k % 8) == 7, (k % 8) != 7, k != 0);
        end
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 1);

        // 3: almost full blocks issue; counter saturates, then issue forced
        for (int k = 0; k < 20; k++) begin
            step(1, 6'h09, 1, 6'(k), 1, 1, 0, 0, 6'h00, 0, 1, k != 0);
        end
        step(1, 6'h0A, 1, 6'h3F, 0, 1, 0, 0, 6'h00, 1, 0, 1);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 1);

        // 4a: held 0x03 killed by branch 0x02 (younger)
        step(0, 6'h00, 1, 6'h03, 0, 1, 0, 0, 6'h00, 0, 1, 0);
        step(1, 6'h0B, 1, 6'h04, 0, 0, 0, 1, 6'h02, 0, 0, 1);
        void'(xfer_q.pop_back());
        step(0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0);
        // 4b: held 0x03 survives branch 0x23 (wrap differs, not younger)
        step(0, 6'h00, 1, 6'h03, 0, 1, 0, 0, 6'h00, 0, 1, 0);
        step(1, 6'h0B, 1, 6'h04, 0, 0, 0, 1, 6'h23, 0, 0, 1);
        step(0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 0, 0, 1);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 1);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 0);

        // 5: replay granted under commit flush is accepted and dropped
        step(0, 6'h00, 1, 6'h10, 0, 1, 1, 0, 6'h00, 0, 1, 0);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 0);

        // 6: counter to 5, stall, async reset mid-cycle
        for (int k = 0; k < 5; k++) begin
            step(1, 6'h0C, 1, 6'(6'h20 + k), 0, 1, 0, 0, 6'h00, 0, 1, k != 0);
        end
        step(1, 6'h0C, 1, 6'h25, 0, 0, 0, 0, 6'h00, 0, 0, 1);
        drive_idle();
        #1;
        i_reset_n = 1'b0;
        void'(xfer_q.pop_back());
        cyc_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        // A counter left at 5 would force issue on the third grant.
        for (int k = 0; k < 8; k++) begin
            step(1, 6'h0D, 1, 6'(6'h28 + k), 0, 1, 0, 0, 6'h00, k == 7, k != 7, k != 0);
        end
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 1);
        step(0, 6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 0, 0, 0);

        end_chk = 1'b1;
        @(negedge i_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
